// File: rtl/act_pingpong_gearbox.sv
// act_pingpong_gearbox
// Packs an AXI-Stream of IN_W-bit beats into OUT_W-bit array vectors
// (little-endian, first stream bit lands in vector bit 0) and writes them
// into one bank of a two-bank ping-pong RAM. The PE array reads the other
// bank with wrap-around so a K-tile can be replayed. A tile closes either
// when the bank holds DEPTH vectors or on tlast (flushing any partial
// vector zero-padded). Bank swaps are refused while a flush is in flight.
module act_pingpong_gearbox #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 96,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             i_bank_swap,
    input  logic             i_rd_en,
    output logic [OUT_W-1:0] o_array_vec,
    output logic             o_vec_valid,
    output logic             o_bank_sel,
    output logic [AW:0]      o_wr_count,
    output logic             o_wr_bank_full,
    output logic             o_swap_err
);

    // The accumulator must hold a residual (< OUT_W bits) plus one fresh beat.
    localparam int ACC_W = IN_W + OUT_W;
    localparam int RW    = $clog2(ACC_W + 1);
    localparam int MEM_N = 2 * (2 ** AW);

    typedef enum logic [1:0] {
        W_FILL  = 2'd0,
        W_FLUSH = 2'd1,
        W_DONE  = 2'd2
    } wstate_e;

    // Both banks share one array; the bank select is the address MSB.
    logic [OUT_W-1:0] mem_q [MEM_N];

    wstate_e          wstate_q,    wstate_d;
    logic             bank_sel_q,  bank_sel_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [RW-1:0]    resid_q,     resid_d;
    logic [AW:0]      wr_count_q,  wr_count_d;
    logic [AW-1:0]    rd_addr_q,   rd_addr_d;
    logic [AW:0]      rd_len_q,    rd_len_d;
    logic [OUT_W-1:0] array_vec_q, array_vec_d;
    logic             vec_valid_q, vec_valid_d;
    logic             swap_err_q,  swap_err_d;

    logic             swap_ok_s;
    logic             ready_s;
    logic             beat_s;
    logic             rd_fire_s;
    logic [ACC_W-1:0] acc_sum_s;
    logic [RW-1:0]    resid_sum_s;
    logic             wr_en_s;
    logic [OUT_W-1:0] wr_data_s;
    logic [AW:0]      wr_idx_s;
    logic [AW:0]      rd_idx_s;

    assign swap_ok_s   = i_bank_swap && (wstate_q != W_FLUSH);
    // A swap request blocks the stream for that cycle so no beat straddles banks.
    assign ready_s     = (wstate_q == W_FILL) && !i_bank_swap;
    assign beat_s      = s_axis_tvalid && ready_s;
    assign acc_sum_s   = acc_q | (ACC_W'(s_axis_tdata) << resid_q);
    assign resid_sum_s = resid_q + RW'(IN_W);
    assign rd_fire_s   = i_rd_en && !swap_ok_s && (rd_len_q != {(AW+1){1'b0}});
    assign wr_idx_s    = {bank_sel_q, wr_count_q[AW-1:0]};
    assign rd_idx_s    = {~bank_sel_q, rd_addr_q};

    assign s_axis_tready  = ready_s;
    assign o_array_vec    = array_vec_q;
    assign o_vec_valid    = vec_valid_q;
    assign o_bank_sel     = bank_sel_q;
    assign o_wr_count     = wr_count_q;
    assign o_wr_bank_full = (wstate_q == W_DONE);
    assign o_swap_err     = swap_err_q;

    // Next-state: write FSM, gearbox packing, swap handling and read pointer.
    always_comb begin
        wstate_d    = wstate_q;
        bank_sel_d  = bank_sel_q;
        acc_d       = acc_q;
        resid_d     = resid_q;
        wr_count_d  = wr_count_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        array_vec_d = array_vec_q;
        vec_valid_d = 1'b0;
        swap_err_d  = i_bank_swap && (wstate_q == W_FLUSH);
        wr_en_s     = 1'b0;
        wr_data_s   = {OUT_W{1'b0}};

        if (swap_ok_s) begin
            // Hand the written bank to the reader; any unterminated partial vector is lost.
            bank_sel_d = ~bank_sel_q;
            rd_len_d   = wr_count_q;
            rd_addr_d  = {AW{1'b0}};
            wstate_d   = W_FILL;
            wr_count_d = {(AW+1){1'b0}};
            acc_d      = {ACC_W{1'b0}};
            resid_d    = {RW{1'b0}};
        end else begin
            case (wstate_q)
                W_FILL: begin
                    if (beat_s) begin
                        acc_d   = acc_sum_s;
                        resid_d = resid_sum_s;
                        if (resid_sum_s >= RW'(OUT_W)) begin
                            wr_en_s    = 1'b1;
                            wr_data_s  = acc_sum_s[OUT_W-1:0];
                            acc_d      = acc_sum_s >> OUT_W;
                            resid_d    = resid_sum_s - RW'(OUT_W);
                            wr_count_d = wr_count_q + (AW+1)'(1);
                        end else begin
                            wr_count_d = wr_count_q;
                        end
                        // A full bank closes the tile even if tlast came with it.
                        if (wr_count_d == (AW+1)'(DEPTH)) begin
                            wstate_d = W_DONE;
                            acc_d    = {ACC_W{1'b0}};
                            resid_d  = {RW{1'b0}};
                        end else if (s_axis_tlast) begin
                            if (resid_d != {RW{1'b0}}) begin
                                wstate_d = W_FLUSH;
                            end else begin
                                wstate_d = W_DONE;
                            end
                        end else begin
                            wstate_d = W_FILL;
                        end
                    end else begin
                        wstate_d = W_FILL;
                    end
                end
                W_FLUSH: begin
                    // Bits above the residual are already zero, giving the zero pad.
                    wr_en_s    = 1'b1;
                    wr_data_s  = acc_q[OUT_W-1:0];
                    wr_count_d = wr_count_q + (AW+1)'(1);
                    acc_d      = {ACC_W{1'b0}};
                    resid_d    = {RW{1'b0}};
                    wstate_d   = W_DONE;
                end
                W_DONE: begin
                    wstate_d = W_DONE;
                end
                default: begin
                    wstate_d = W_FILL;
                end
            endcase
        end

        if (rd_fire_s) begin
            array_vec_d = mem_q[rd_idx_s];
            vec_valid_d = 1'b1;
            if (((AW+1)'(rd_addr_q) + (AW+1)'(1)) == rd_len_q) begin
                rd_addr_d = {AW{1'b0}};
            end else begin
                rd_addr_d = rd_addr_q + AW'(1);
            end
        end else begin
            vec_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q    <= W_FILL;
            bank_sel_q  <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            resid_q     <= {RW{1'b0}};
            wr_count_q  <= {(AW+1){1'b0}};
            rd_addr_q   <= {AW{1'b0}};
            rd_len_q    <= {(AW+1){1'b0}};
            array_vec_q <= {OUT_W{1'b0}};
            vec_valid_q <= 1'b0;
            swap_err_q  <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            bank_sel_q  <= bank_sel_d;
            acc_q       <= acc_d;
            resid_q     <= resid_d;
            wr_count_q  <= wr_count_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            array_vec_q <= array_vec_d;
            vec_valid_q <= vec_valid_d;
            swap_err_q  <= swap_err_d;
        end
    end

    // Bank RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= wr_data_s;
        end
    end

endmodule
